// File: rtl/key_press_counter.sv
`default_nettype none
// ============================================================================
// Module      : key_press_counter
// Description : Classifies presses of a debounced key by hold time. A short
//               press increments a DIGITS-digit BCD counter on release; a long
//               press clears it. The count is shown on a multiplexed,
//               active-low 7-segment display, and single-cycle event pulses
//               are emitted for downstream logic and LEDs.
// Ports       :
//   clk          in   system clock, all logic on the rising edge
//   rst          in   asynchronous, active-high reset
//   key_in       in   debounced key level
//   count        out  BCD count, digit 0 in bits [3:0]
//   press_pulse  out  one-cycle high when the count increments
//   clr_pulse    out  one-cycle high when a long press clears the count
//   ovf_pulse    out  one-cycle high when the count wraps all-9s -> all-0s
//   seg          out  active-low segments, seg[0]=a .. seg[6]=g
//   dig_sel      out  active-low one-hot digit enable
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_counter #(
    parameter int   DIGITS      = 2,
    parameter int   LONG_PRESS  = 8,
    parameter int   SCAN_DIV    = 4,
    parameter logic PRESS_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_in,
    output logic [4*DIGITS-1:0] count,
    output logic                press_pulse,
    output logic                clr_pulse,
    output logic                ovf_pulse,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_sel
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_HOLD_W = $clog2(LONG_PRESS + 1);
    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_PRESS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_ONE  = c_SCAN_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [DIGITS-1:0]   c_DIG_ONE   = DIGITS'(1);

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HELD = 2'd1;
    localparam logic [1:0] c_ST_LONG = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                r_key;
    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [4*DIGITS-1:0] r_count;
    logic                r_press;
    logic                r_clr;
    logic                r_ovf;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0]   r_dig_sel;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic                w_pressed;
    logic [1:0]          w_state_next;
    logic [c_HOLD_W-1:0] w_hold_next;
    logic [4*DIGITS-1:0] w_count_next;
    logic                w_press_next;
    logic                w_clr_next;
    logic                w_ovf_next;
    logic [4*DIGITS-1:0] w_count_inc;
    logic                w_carry;
    logic                w_all_nines;
    logic                w_scan_wrap;
    logic [c_SCAN_W-1:0] w_scan_next;
    logic [c_IDX_W-1:0]  w_idx_next;
    logic [3:0]          w_digit;

    assign w_pressed = (r_key == PRESS_LEVEL);

    // ------------------------------------------------------------------------
    // BCD increment: a ripple carry enters digit 0; every digit at 9 rolls to
    // 0 and passes the carry on. A carry surviving past the top digit means
    // the whole count was all-9s, which is the overflow condition.
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        w_all_nines = w_carry;
    end

    // ------------------------------------------------------------------------
    // Press classification FSM: next-state and event logic.
    // In HELD the release test comes before the threshold test, so a release
    // can never be mistaken for a long press on the same sample.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_count_next = r_count;
        w_press_next = 1'b0;
        w_clr_next   = 1'b0;
        w_ovf_next   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pressed) begin
                    w_state_next = c_ST_HELD;
                    w_hold_next  = c_HOLD_ONE;
                end
            end
            c_ST_HELD: begin
                if (!w_pressed) begin
                    w_state_next = c_ST_IDLE;
                    w_count_next = w_count_inc;
                    w_press_next = 1'b1;
                    w_ovf_next   = w_all_nines;
                end else if (r_hold_cnt == c_HOLD_MAX) begin
                    w_state_next = c_ST_LONG;
                    w_count_next = '0;
                    w_clr_next   = 1'b1;
                end else begin
                    w_hold_next = r_hold_cnt + c_HOLD_ONE;
                end
            end
            c_ST_LONG: begin
                // The clear already happened; just wait for the release.
                if (!w_pressed) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_hold_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Key sampling, FSM state, count and event pulse registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key      <= ~PRESS_LEVEL;
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
            r_count    <= '0;
            r_press    <= 1'b0;
            r_clr      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_key      <= key_in;
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_count    <= w_count_next;
            r_press    <= w_press_next;
            r_clr      <= w_clr_next;
            r_ovf      <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------------
    // Display scan: free-running, independent of the FSM. dig_sel is
    // registered from the same next index as r_idx, so it always matches the
    // digit being decoded onto seg.
    // ------------------------------------------------------------------------
    assign w_scan_wrap = (r_scan_cnt == c_SCAN_LAST);
    assign w_scan_next = w_scan_wrap ? '0 : (r_scan_cnt + c_SCAN_ONE);

    always_comb begin
        w_idx_next = r_idx;
        if (w_scan_wrap) begin
            if (r_idx == c_IDX_LAST) begin
                w_idx_next = '0;
            end else begin
                w_idx_next = r_idx + c_IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_dig_sel  <= ~c_DIG_ONE;
        end else begin
            r_scan_cnt <= w_scan_next;
            r_idx      <= w_idx_next;
            r_dig_sel  <= ~(c_DIG_ONE << w_idx_next);
        end
    end

    // Select the digit currently being scanned.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit = r_count[4*i +: 4];
            end
        end
    end

    // Active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
    // Codes 10..15 cannot occur and blank the digit.
    always_comb begin
        case (w_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign count       = r_count;
    assign press_pulse = r_press;
    assign clr_pulse   = r_clr;
    assign ovf_pulse   = r_ovf;
    assign dig_sel     = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_key_press_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_press_counter
// Description : Self-checking bench for key_press_counter (DIGITS=2,
//               LONG_PRESS=8, SCAN_DIV=4, PRESS_LEVEL=0). Each stimulus task
//               pushes the pulse events it expects onto a queue; a negedge
//               monitor pops and compares them as the DUT emits pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_press_counter;

    localparam int DIGITS     = 2;
    localparam int LONG_PRESS = 8;
    localparam int SCAN_DIV   = 4;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic [7:0] count;
    logic       press_pulse;
    logic       clr_pulse;
    logic       ovf_pulse;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    typedef struct packed {
        logic       press;
        logic       clr;
        logic       ovf;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   model  = 0;   // decimal value the count should hold
    logic mon_en = 1'b0;

    key_press_counter #(
        .DIGITS      (DIGITS),
        .LONG_PRESS  (LONG_PRESS),
        .SCAN_DIV    (SCAN_DIV),
        .PRESS_LEVEL (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .count       (count),
        .press_pulse (press_pulse),
        .clr_pulse   (clr_pulse),
        .ovf_pulse   (ovf_pulse),
        .seg         (seg),
        .dig_sel     (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    // Scoreboard monitor: every pulse cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && (press_pulse || clr_pulse || ovf_pulse)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got press=%b clr=%b ovf=%b count=%h, required no pulse",
                         press_pulse, clr_pulse, ovf_pulse, count);
            end else begin
                mon_e = exp_q.pop_front();
                if ({press_pulse, clr_pulse, ovf_pulse, count} !== mon_e) begin
                    errors++;
                    $display("FAIL pulse_event: got press=%b clr=%b ovf=%b count=%h, required press=%b clr=%b ovf=%b count=%h",
                             press_pulse, clr_pulse, ovf_pulse, count,
                             mon_e.press, mon_e.clr, mon_e.ovf, mon_e.count);
                end
            end
        end
    end

    // Push the event a press of n pressed samples should produce.
    task automatic expect_for(input int n);
        exp_t e;
        if (n <= LONG_PRESS) begin
            e.press = 1'b1;
            e.clr   = 1'b0;
            e.ovf   = (model == 99);
            model   = (model + 1) % 100;
            e.count = to_bcd(model);
        end else begin
            model = 0;
            e     = {1'b0, 1'b1, 1'b0, 8'h00};
        end
        exp_q.push_back(e);
    endtask

    // Give pending pulses time to appear, then require the queue to be empty.
    task automatic drain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected pulse(s) not seen, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // key_in low for exactly n sampling edges, then released.
    task automatic do_press(input int n);
        expect_for(n);
        @(posedge clk);
        #1 key_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        key_in = 1'b1;
        drain();
    endtask

    task automatic check_count(input string name, input logic [7:0] req);
        checks++;
        if (count !== req) begin
            errors++;
            $display("FAIL %s: count=%h, required %h", name, count, req);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        key_in = 1'b1;
        #3 rst = 1'b1;
        #1;  // before any clock edge: reset acts asynchronously
        check_count("reset_count_async", 8'h00);
        checks++;
        if ({press_pulse, clr_pulse, ovf_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 000", {press_pulse, clr_pulse, ovf_pulse});
        end
        checks++;
        if (dig_sel !== 2'b10) begin
            errors++;
            $display("FAIL reset_dig_sel: got %b, required 10", dig_sel);
        end
        checks++;
        if (seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_seg: got %b, required 1000000", seg);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dig_sel !== 2'b10) begin
            errors++;
            $display("FAIL reset_hold_dig_sel: got %b, required 10", dig_sel);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_count("post_reset_idle", 8'h00);
        model  = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_short_press();
        expect_for(3);
        @(posedge clk);
        #1 key_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        key_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_early: press_pulse=%b one cycle after release, required 0", press_pulse);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (press_pulse !== 1'b1 || clr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_timing: press=%b clr=%b two cycles after release, required press=1 clr=0",
                     press_pulse, clr_pulse);
        end
        drain();
        check_count("short_count", 8'h01);
    endtask

    task automatic test_long_threshold();
        while (model != 7) do_press(2);
        check_count("long_setup", 8'h07);
        do_press(LONG_PRESS);
        check_count("hold_8_is_short", 8'h08);
        do_press(LONG_PRESS + 1);
        check_count("hold_9_clears", 8'h00);
        do_press(2);
        check_count("long50_setup", 8'h01);
        do_press(50);
        check_count("hold_50_clears", 8'h00);
    endtask

    task automatic test_carry();
        repeat (10) do_press(2);
        check_count("carry_10", 8'h10);
    endtask

    task automatic test_wrap();
        while (model != 99) do_press(1);
        check_count("wrap_setup", 8'h99);
        do_press(1);
        check_count("wrap_to_zero", 8'h00);
    endtask

    // Three one-sample presses separated by one released sample each.
    task automatic test_back_to_back();
        repeat (3) expect_for(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            key_in = 1'b0;
            @(posedge clk);
            #1 key_in = 1'b1;
            @(posedge clk);
            #1;
        end
        drain();
        check_count("back_to_back", 8'h03);
    endtask

    task automatic test_scan();
        logic [1:0] prev;
        int         run;
        int         changes;
        while (model != 42) do_press(2);
        check_count("scan_setup", 8'h42);
        run     = 0;
        changes = 0;
        prev    = 2'b00;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel == 2'b10) begin
                if (seg !== 7'b0100100) begin
                    errors++;
                    $display("FAIL scan_seg_d0: seg=%b, required 0100100", seg);
                end
            end else if (dig_sel == 2'b01) begin
                if (seg !== 7'b0011001) begin
                    errors++;
                    $display("FAIL scan_seg_d1: seg=%b, required 0011001", seg);
                end
            end else begin
                errors++;
                $display("FAIL scan_dig_sel: dig_sel=%b, required 10 or 01", dig_sel);
            end
            if (i > 0 && dig_sel != prev) begin
                if (changes > 0) begin
                    checks++;
                    if (run != SCAN_DIV) begin
                        errors++;
                        $display("FAIL scan_period: digit held %0d cycles, required %0d", run, SCAN_DIV);
                    end
                end
                changes++;
                run = 1;
            end else begin
                run++;
            end
            prev = dig_sel;
        end
        checks++;
        if (changes < 4) begin
            errors++;
            $display("FAIL scan_toggles: %0d digit changes in 24 cycles, required at least 4", changes);
        end
    endtask

    task automatic test_reset_mid_press();
        @(posedge clk);
        #1 key_in = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_count("mid_reset_count_async", 8'h00);
        checks++;
        if (dig_sel !== 2'b10 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_reset_display: dig_sel=%b seg=%b, required 10 1000000", dig_sel, seg);
        end
        model = 0;
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        // Key still held: a fresh short press of three samples.
        expect_for(3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        key_in = 1'b1;
        drain();
        check_count("mid_reset_new_press", 8'h01);
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_threshold();
        test_carry();
        test_wrap();
        test_back_to_back();
        test_scan();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
